// File: rtl/mux2_bus_arbiter_pkg.sv
// Shared encodings for the two-requester packet arbiter: FSM states and mux select values.
package mux2_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Round-robin tie break: the side that did not win last time gets the grant.
  function automatic arb_state_t rr_tie_winner(input logic last_win);
    return (last_win == SEL_A) ? ST_GNT_B : ST_GNT_A;
  endfunction

endpackage

// File: rtl/mux2_bus_arbiter_mux2_bus.sv
// WIDTH-bit 2:1 mux shared by the arbiter for beat data and for the last flag.
module mux2_bus
  import mux2_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] z
);

  assign z = (c == SEL_B) ? b : a;

endmodule

// File: rtl/mux2_bus_arbiter.sv
// Packet arbiter steering requester A or B through a shared 2:1 mux to one valid/ready consumer.
// Optional macro ARB_FIXED_PRIO_A_EN: A wins every tie (round-robin via last_win otherwise).
module mux2_bus_arbiter
  import mux2_bus_arbiter_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MAX_BEATS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy,
  output logic             wd_err
);

  localparam int              CNT_W    = $clog2(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  arb_state_t       state;
  arb_state_t       nxt_state;
  arb_state_t       idle_pick;
  arb_state_t       done_pick;
  logic             last_win;
  logic [CNT_W-1:0] beat_cnt;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;
  logic             beat;
  logic             wd_hit;
  logic             pkt_done;

  mux2_bus #(.WIDTH(WIDTH)) u_data_mux (.a(a_data), .b(b_data), .c(sel), .z(mux_data));
  mux2_bus #(.WIDTH(1))     u_last_mux (.a(a_last), .b(b_last), .c(sel), .z(mux_last));

  assign busy      = (state == ST_GNT_A) || (state == ST_GNT_B);
  assign out_valid = ((state == ST_GNT_A) && a_valid) || ((state == ST_GNT_B) && b_valid);
  assign out_data  = busy ? mux_data : '0;
  assign out_last  = busy & mux_last;
  assign a_ready   = (state == ST_GNT_A) && out_ready;
  assign b_ready   = (state == ST_GNT_B) && out_ready;

  assign beat     = out_valid && out_ready;
  assign wd_hit   = beat && !out_last && (beat_cnt == CNT_LAST);
  assign pkt_done = beat && (out_last || wd_hit);

  always_comb begin
    idle_pick = ST_IDLE;
    if (a_valid && b_valid) begin
`ifdef ARB_FIXED_PRIO_A_EN
      idle_pick = ST_GNT_A;
`else
      idle_pick = rr_tie_winner(last_win);
`endif
    end else if (a_valid) begin
      idle_pick = ST_GNT_A;
    end else if (b_valid) begin
      idle_pick = ST_GNT_B;
    end

    // Re-arbitration at packet end never hands the grant straight back to the same side.
    done_pick = ST_IDLE;
    if (state == ST_GNT_A) begin
`ifdef ARB_FIXED_PRIO_A_EN
      // A is still valid on its own last beat, so a tie with B resolves to A via IDLE.
      done_pick = ST_IDLE;
`else
      done_pick = b_valid ? ST_GNT_B : ST_IDLE;
`endif
    end else if (state == ST_GNT_B) begin
      done_pick = a_valid ? ST_GNT_A : ST_IDLE;
    end

    nxt_state = state;
    case (state)
      ST_IDLE:            nxt_state = idle_pick;
      ST_GNT_A, ST_GNT_B: if (pkt_done) nxt_state = done_pick;
      default:            nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= SEL_A;
      last_win <= SEL_B;
      beat_cnt <= '0;
      wd_err   <= 1'b0;
    end else begin
      state  <= nxt_state;
      wd_err <= wd_hit;
      if (nxt_state == ST_GNT_A && state != ST_GNT_A) sel <= SEL_A;
      if (nxt_state == ST_GNT_B && state != ST_GNT_B) sel <= SEL_B;
      if (pkt_done) begin
        last_win <= sel;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// Directed and scoreboard checks for mux2_bus_arbiter (WIDTH=2, MAX_BEATS=8).
module tb_mux2_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [1:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [1:0] b_data;
  logic       out_valid, out_last, out_ready;
  logic [1:0] out_data;
  logic       sel, busy, wd_err;

  int errors = 0;
  int checks = 0;

  mux2_bus_arbiter #(.WIDTH(2), .MAX_BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 0; a_data = 0; a_last = 0;
    b_valid = 0; b_data = 0; b_last = 0; out_ready = 1;
    #1;
    checks++; if ({out_valid, out_data, out_last, a_ready, b_ready, sel, busy, wd_err} !== 9'd0) begin errors++; $display("FAIL reset_init outputs got=%b exp=0", {out_valid, out_data, out_last, a_ready, b_ready, sel, busy, wd_err}); end
    step(); rst_n = 1'b1;
    b_valid = 1; b_data = 2'b11; b_last = 0;
    step();
    checks++; if ({sel, busy, out_valid, out_data, b_ready} !== 6'b111111) begin errors++; $display("FAIL reset_pre_gntb got=%b exp=111111", {sel, busy, out_valid, out_data, b_ready}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_data, out_last, a_ready, b_ready, sel, busy, wd_err} !== 9'd0) begin errors++; $display("FAIL reset_async outputs got=%b exp=0", {out_valid, out_data, out_last, a_ready, b_ready, sel, busy, wd_err}); end
    b_valid = 0;
    step(); rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_a();
    logic [1:0] d [3];
    logic       l [3];
    d = '{2'b01, 2'b10, 2'b11};
    l = '{1'b0, 1'b0, 1'b1};
    a_valid = 1; a_data = d[0]; a_last = l[0]; out_ready = 1;
    #1;
    checks++; if ({out_valid, a_ready, busy} !== 3'b000) begin errors++; $display("FAIL single_idle_mask got=%b exp=000", {out_valid, a_ready, busy}); end
    step();
    checks++; if ({busy, sel} !== 2'b10) begin errors++; $display("FAIL single_grant busy,sel got=%b exp=10", {busy, sel}); end
    for (int i = 0; i < 3; i++) begin
      a_data = d[i]; a_last = l[i];
      #1;
      checks++; if ({out_valid, out_data, out_last, a_ready} !== {1'b1, d[i], l[i], 1'b1}) begin errors++; $display("FAIL single_beat%0d got=%b exp=%b", i, {out_valid, out_data, out_last, a_ready}, {1'b1, d[i], l[i], 1'b1}); end
      step();
    end
    a_valid = 0; a_last = 0;
    #1;
    checks++; if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL single_idle_after got=%b exp=00", {busy, out_valid}); end
  endtask

`ifndef ARB_FIXED_PRIO_A_EN
  task automatic test_round_robin();
    rst_n = 0; #1; rst_n = 1;
    a_valid = 1; a_data = 2'b00; a_last = 0;
    b_valid = 1; b_data = 2'b10; b_last = 0; out_ready = 1;
    step();
    checks++; if ({busy, sel, out_data, a_ready, b_ready} !== 6'b100010) begin errors++; $display("FAIL rr_first_tie_a got=%b exp=100010", {busy, sel, out_data, a_ready, b_ready}); end
    step();
    a_data = 2'b01; a_last = 1;
    #1;
    checks++; if ({out_data, out_last} !== 3'b011) begin errors++; $display("FAIL rr_a_last got=%b exp=011", {out_data, out_last}); end
    step();
    a_data = 2'b10; a_last = 1;
    checks++; if ({busy, sel, out_data, b_ready, a_ready} !== 6'b111010) begin errors++; $display("FAIL rr_b_no_bubble got=%b exp=111010", {busy, sel, out_data, b_ready, a_ready}); end
    step();
    b_data = 2'b11; b_last = 1;
    #1;
    checks++; if ({out_data, out_last} !== 3'b111) begin errors++; $display("FAIL rr_b_last got=%b exp=111", {out_data, out_last}); end
    step();
    b_valid = 0; b_last = 0;
    checks++; if ({busy, sel, out_data, out_last} !== 5'b10101) begin errors++; $display("FAIL rr_back_to_a got=%b exp=10101", {busy, sel, out_data, out_last}); end
    step();
    a_valid = 0; a_last = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_idle got=%b exp=0", busy); end
  endtask
`else
  task automatic test_round_robin();
    rst_n = 0; #1; rst_n = 1;
    a_valid = 1; a_data = 2'b01; a_last = 1;
    b_valid = 1; b_data = 2'b10; b_last = 1; out_ready = 1;
    for (int r = 0; r < 2; r++) begin
      step();
      checks++; if ({busy, sel, out_data} !== 4'b1001) begin errors++; $display("FAIL fp_tie%0d got=%b exp=1001", r, {busy, sel, out_data}); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fp_idle%0d got=%b exp=0", r, busy); end
    end
    a_valid = 0;
    step();
    checks++; if ({busy, sel} !== 2'b11) begin errors++; $display("FAIL fp_b_alone got=%b exp=11", {busy, sel}); end
    b_valid = 0;
    step(); step();
  endtask
`endif

  task automatic test_stall();
    a_valid = 1; a_data = 2'b01; a_last = 0; b_valid = 0; out_ready = 1;
    step();
    b_valid = 1; b_data = 2'b11; b_last = 1;
    step();
    a_data = 2'b10; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({a_ready, b_ready, out_data, out_valid, sel, busy} !== 7'b0010101) begin errors++; $display("FAIL stall_cyc%0d got=%b exp=0010101", i, {a_ready, b_ready, out_data, out_valid, sel, busy}); end
      step();
    end
    out_ready = 1; a_last = 1;
    #1;
    checks++; if ({a_ready, out_data, out_last} !== 4'b1101) begin errors++; $display("FAIL stall_resume got=%b exp=1101", {a_ready, out_data, out_last}); end
    step();
    a_valid = 0; a_last = 0;
    checks++; if ({busy, sel, out_data, b_ready} !== 5'b11111) begin errors++; $display("FAIL stall_to_b got=%b exp=11111", {busy, sel, out_data, b_ready}); end
    step();
    b_valid = 0; b_last = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end_idle got=%b exp=0", busy); end
  endtask

  task automatic test_watchdog();
    for (int rep = 0; rep < 2; rep++) begin
      a_valid = 1; a_data = 0; a_last = 0; b_valid = 0; out_ready = 1;
      step();
      if (rep == 1) begin b_valid = 1; b_data = 2'b01; b_last = 1; end
      for (int i = 0; i < 8; i++) begin
        a_data = 2'(i);
        #1;
        checks++; if ({a_ready, out_data, wd_err} !== {1'b1, 2'(i), 1'b0}) begin errors++; $display("FAIL wd%0d_beat%0d got=%b exp=%b", rep, i, {a_ready, out_data, wd_err}, {1'b1, 2'(i), 1'b0}); end
        step();
      end
      if (rep == 0) begin
        checks++; if ({wd_err, busy} !== 2'b10) begin errors++; $display("FAIL wd0_release got=%b exp=10", {wd_err, busy}); end
        step();
        checks++; if ({wd_err, busy, sel} !== 3'b010) begin errors++; $display("FAIL wd0_regrant got=%b exp=010", {wd_err, busy, sel}); end
        a_data = 0; step();
        a_last = 1; step();
        a_valid = 0; a_last = 0;
        checks++; if ({wd_err, busy} !== 2'b00) begin errors++; $display("FAIL wd0_tail got=%b exp=00", {wd_err, busy}); end
      end else begin
        a_valid = 0;
        checks++; if ({wd_err, busy, sel, out_data} !== 5'b11101) begin errors++; $display("FAIL wd1_to_b got=%b exp=11101", {wd_err, busy, sel, out_data}); end
        step();
        b_valid = 0; b_last = 0;
        checks++; if ({wd_err, busy} !== 2'b00) begin errors++; $display("FAIL wd1_end got=%b exp=00", {wd_err, busy}); end
      end
    end
  endtask

  task automatic test_scoreboard();
    logic [1:0] a_hd, b_hd;
    logic       a_hl, b_hl;
    logic       wd_exp;
    logic       ta, tb, exp_l;
    logic [1:0] exp_d;
    int         owner, beats, xfers;
    a_hd = 0; b_hd = 2; a_hl = 0; b_hl = 1;
    wd_exp = 0; owner = -1; beats = 0; xfers = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      a_valid = ($urandom_range(0, 3) != 0); a_data = a_hd; a_last = a_hl;
      b_valid = ($urandom_range(0, 3) != 0); b_data = b_hd; b_last = b_hl;
      out_ready = ($urandom_range(0, 3) != 0);
      #3;
      checks++; if (wd_err !== wd_exp) begin errors++; $display("FAIL sb_wd_err cyc=%0d got=%b exp=%b", cyc, wd_err, wd_exp); end
      checks++; if ((a_ready && b_ready) !== 1'b0) begin errors++; $display("FAIL sb_both_ready cyc=%0d got=1 exp=0", cyc); end
      ta = a_valid && a_ready;
      tb = b_valid && b_ready;
      wd_exp = 0;
      if (ta || tb) begin
        xfers++;
        exp_d = ta ? a_hd : b_hd;
        exp_l = ta ? a_hl : b_hl;
        checks++; if ({out_valid, out_data, out_last} !== {1'b1, exp_d, exp_l}) begin errors++; $display("FAIL sb_beat cyc=%0d side=%0d got=%b exp=%b", cyc, tb, {out_valid, out_data, out_last}, {1'b1, exp_d, exp_l}); end
        checks++; if (owner != -1 && owner != int'(tb)) begin errors++; $display("FAIL sb_interleave cyc=%0d got=%0d exp=%0d", cyc, tb, owner); end
        owner = int'(tb);
        beats++;
        if (exp_l || beats == 8) begin
          wd_exp = !exp_l;
          owner = -1;
          beats = 0;
        end
        if (ta) begin a_hd = a_hd + 1; a_hl = ($urandom_range(0, 3) == 0); end
        else    begin b_hd = b_hd + 1; b_hl = ($urandom_range(0, 3) == 0); end
      end
      step();
    end
    checks++; if (xfers < 100) begin errors++; $display("FAIL sb_traffic got=%0d exp>=100", xfers); end
    a_valid = 0; b_valid = 0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_stall();
    test_watchdog();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
